// File: rtl/bus_port_pkg.sv
// Shared defaults and width helper for the per-device bus port FIFOs.
package bus_port_pkg;

    localparam int DEF_PCKG_SZ = 16;
    localparam int DEF_DEPTH   = 8;
    localparam int OVF_W       = 8;

    // Occupancy needs one extra code so that "full" (count == depth) fits.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word fall-through synchronous FIFO with occupancy and saturating drop counter.
// Head is read combinationally from the array; a read and a write when full both succeed.
module sync_fifo_fwft
    import bus_port_pkg::*;
#(
    parameter int width = DEF_PCKG_SZ,
    parameter int depth = DEF_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [width-1:0]            din,
    input  logic                        rd_en,
    output logic [width-1:0]            dout,
    output logic                        full,
    output logic                        empty,
    output logic [cnt_w(depth)-1:0]     count,
    output logic [OVF_W-1:0]            ovf_cnt
);

    localparam int PW = $clog2(depth);
    localparam int CW = cnt_w(depth);

    logic [width-1:0] mem [depth];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_rd;
    logic             do_wr;
    logic             drop;

    assign full  = (count == CW'(depth));
    assign empty = (count == '0);

    // A pop on a full FIFO frees the slot the same edge, so the write is accepted too.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);
    assign drop  = wr_en && !do_wr;

    assign dout = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_cnt <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop && (ovf_cnt != {OVF_W{1'b1}})) begin
                ovf_cnt <= ovf_cnt + OVF_W'(1);
            end
        end
    end

endmodule

// File: rtl/bus_port_fifo.sv
// Device-side port to one bus arbiter port: TX FIFO feeds pndng/D_pop, RX FIFO absorbs push/D_push.
// Heads read as zero whenever the corresponding FIFO is empty.
module bus_port_fifo
    import bus_port_pkg::*;
#(
    parameter int pckg_sz = DEF_PCKG_SZ,
    parameter int depth   = DEF_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        dev_wr_en,
    input  logic [pckg_sz-1:0]          dev_wr_data,
    output logic                        dev_wr_full,
    input  logic                        dev_rd_en,
    output logic [pckg_sz-1:0]          dev_rd_data,
    output logic                        dev_rd_empty,
    output logic                        pndng,
    output logic [pckg_sz-1:0]          D_pop,
    input  logic                        pop,
    input  logic                        push,
    input  logic [pckg_sz-1:0]          D_push,
    output logic [cnt_w(depth)-1:0]     tx_count,
    output logic [cnt_w(depth)-1:0]     rx_count,
    output logic [OVF_W-1:0]            tx_ovf_cnt,
    output logic [OVF_W-1:0]            rx_ovf_cnt
);

    logic [pckg_sz-1:0] tx_dout;
    logic [pckg_sz-1:0] rx_dout;
    logic               tx_empty;
    logic               rx_full;

    sync_fifo_fwft #(.width(pckg_sz), .depth(depth)) u_tx (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (dev_wr_en),
        .din     (dev_wr_data),
        .rd_en   (pop),
        .dout    (tx_dout),
        .full    (dev_wr_full),
        .empty   (tx_empty),
        .count   (tx_count),
        .ovf_cnt (tx_ovf_cnt)
    );

    sync_fifo_fwft #(.width(pckg_sz), .depth(depth)) u_rx (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .din     (D_push),
        .rd_en   (dev_rd_en),
        .dout    (rx_dout),
        .full    (rx_full),
        .empty   (dev_rd_empty),
        .count   (rx_count),
        .ovf_cnt (rx_ovf_cnt)
    );

    // Stale array contents must never leak onto the bus or to the device.
    assign pndng       = !tx_empty;
    assign D_pop       = tx_empty ? '0 : tx_dout;
    assign dev_rd_data = dev_rd_empty ? '0 : rx_dout;

endmodule

// File: tb/tb_bus_port_fifo.sv
// Four port instances on a modelled bus; scoreboard queues for TX of port 0 and RX of port 3.
module tb_bus_port_fifo;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] wr_en  = '0;
    logic [N-1:0] rd_en  = '0;
    logic [N-1:0] pop    = '0;
    logic [N-1:0] push   = '0;
    logic [15:0]  wr_data [N];
    logic [15:0]  d_push  [N];
    wire  [N-1:0] full;
    wire  [N-1:0] empty;
    wire  [N-1:0] pndng;
    wire  [15:0]  rd_data [N];
    wire  [15:0]  d_pop   [N];
    wire  [3:0]   txc     [N];
    wire  [3:0]   rxc     [N];
    wire  [7:0]   txo     [N];
    wire  [7:0]   rxo     [N];

    for (genvar g = 0; g < N; g++) begin : g_port
        bus_port_fifo dut (
            .clk          (clk),
            .reset        (reset),
            .dev_wr_en    (wr_en[g]),
            .dev_wr_data  (wr_data[g]),
            .dev_wr_full  (full[g]),
            .dev_rd_en    (rd_en[g]),
            .dev_rd_data  (rd_data[g]),
            .dev_rd_empty (empty[g]),
            .pndng        (pndng[g]),
            .D_pop        (d_pop[g]),
            .pop          (pop[g]),
            .push         (push[g]),
            .D_push       (d_push[g]),
            .tx_count     (txc[g]),
            .rx_count     (rxc[g]),
            .tx_ovf_cnt   (txo[g]),
            .rx_ovf_cnt   (rxo[g])
        );
    end

    int total = 0;
    int bad   = 0;
    logic [15:0] sb [$];
    logic [15:0] rx_sb [$];
    int ovf_m = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle on port 0 TX; inputs are driven 1ns after an edge and checked 1ns after the next.
    task automatic step(input logic w, input logic [15:0] d, input logic p);
        logic [15:0] e;
        bit rd_ok;
        bit wr_ok;
        rd_ok = p && (sb.size() > 0);
        wr_ok = w && (sb.size() < 8 || rd_ok);
        if (rd_ok) begin
            e = sb.pop_front();
            chk("d_pop_head", d_pop[0], e);
        end
        if (w && !wr_ok && ovf_m != 255) ovf_m++;
        if (wr_ok) sb.push_back(d);
        wr_en[0] = w;
        wr_data[0] = d;
        pop[0] = p;
        @(posedge clk); #1;
        wr_en[0] = 1'b0;
        pop[0] = 1'b0;
    endtask

    task automatic chk_tx(input string tag);
        chk({tag, "_count"}, txc[0], sb.size());
        chk({tag, "_pndng"}, pndng[0], sb.size() != 0);
        chk({tag, "_full"}, full[0], sb.size() == 8);
        chk({tag, "_ovf"}, txo[0], ovf_m);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            wr_data[i] = '0;
            d_push[i] = '0;
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < N; i++) begin
            chk("rst_pndng", pndng[i], 1'b0);
            chk("rst_full", full[i], 1'b0);
            chk("rst_empty", empty[i], 1'b1);
            chk("rst_d_pop", d_pop[i], 16'h0000);
            chk("rst_rd_data", rd_data[i], 16'h0000);
        end

        // 1: reset asserted mid-traffic clears state asynchronously
        step(1, 16'h1111, 0);
        step(1, 16'h2222, 0);
        step(1, 16'h3333, 0);
        chk_tx("pre_rst");
        reset = 1'b1;
        #1;
        chk("async_pndng", pndng[0], 1'b0);
        chk("async_count", txc[0], 0);
        chk("async_d_pop", d_pop[0], 16'h0000);
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        ovf_m = 0;
        @(posedge clk); #1;
        chk_tx("post_rst");

        // 2: ordering
        step(1, 16'hA001, 0);
        chk("first_head", d_pop[0], 16'hA001);
        step(1, 16'hA002, 0);
        step(1, 16'hA003, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 16'h0, 1);
            chk_tx("order");
        end
        chk("empty_d_pop", d_pop[0], 16'h0000);

        // pop on empty is ignored
        step(0, 16'h0, 1);
        chk_tx("pop_empty");

        // 3: overflow
        for (int i = 0; i < 10; i++) step(1, 16'hB000 + 16'(i), 0);
        chk_tx("ovf");
        chk("ovf_two", txo[0], 8'd2);

        // 4: write and pop together when full
        step(1, 16'hC0DE, 1);
        chk_tx("full_wr_rd");
        for (int i = 0; i < 8; i++) step(0, 16'h0, 1);
        chk_tx("drain4");

        // simultaneous write and pop when empty: write only
        step(1, 16'hE001, 1);
        chk_tx("empty_wr_rd");
        step(0, 16'h0, 1);

        // 6: saturation then wrap
        for (int i = 0; i < 8; i++) step(1, 16'hD000 + 16'(i), 0);
        for (int i = 0; i < 300; i++) step(1, 16'hFFFF, 0);
        chk_tx("sat");
        chk("sat_255", txo[0], 8'd255);
        for (int i = 0; i < 8; i++) step(0, 16'h0, 1);
        for (int i = 0; i < 20; i++) begin
            step(1, 16'h5A00 ^ 16'(i * 16'h0137), 0);
            step(0, 16'h0, 1);
        end
        chk_tx("wrap");

        // 5: port 0 sends header 8'h03 packet; bus delivers it to port 3
        step(1, 16'h03BE, 0);
        chk("bus_src_head", d_pop[0], 16'h03BE);
        pop[0] = pndng[0];
        push[d_pop[0][15:8]] = 1'b1;
        d_push[d_pop[0][15:8]] = d_pop[0];
        rx_sb.push_back(16'h03BE);
        sb.delete();
        @(posedge clk); #1;
        pop[0] = 1'b0;
        push = '0;
        chk("bus_src_count", txc[0], 0);
        chk("rx3_count", rxc[3], rx_sb.size());
        chk("rx3_empty", empty[3], 1'b0);
        chk("rx3_data", rd_data[3], rx_sb.pop_front());
        for (int i = 0; i < 3; i++) begin
            chk("rxk_count", rxc[i], 0);
            chk("rxk_empty", empty[i], 1'b1);
        end
        for (int i = 1; i < 3; i++) chk("txk_count", txc[i], 0);
        rd_en[3] = 1'b1;
        @(posedge clk); #1;
        rd_en[3] = 1'b0;
        chk("rx3_drained", rxc[3], rx_sb.size());
        chk("rx3_zero", rd_data[3], 16'h0000);
        chk("rx3_ovf", rxo[3], 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
